// File: rtl/axi_cmd_frontend_if.sv
// AXI address/response bundle for the LPDDR4 command front-end.
// Carries the AW, AR and B channels, the native command port and the
// write-completion pulse. The front-end is the AXI slave; the master
// modport is the view of whatever drives it (interconnect or bench).
interface axi_cmd_frontend_if;

  // Write address channel
  logic        axi_aw_valid;
  logic        axi_aw_ready;
  logic [31:0] axi_aw_payload_addr;
  logic [7:0]  axi_aw_payload_len;
  logic [1:0]  axi_aw_payload_burst;
  logic        axi_aw_payload_id;
  logic [3:0]  axi_aw_payload_size;
  logic [1:0]  axi_aw_payload_lock;
  logic [2:0]  axi_aw_payload_prot;
  logic [3:0]  axi_aw_payload_cache;
  logic [3:0]  axi_aw_payload_qos;
  logic        axi_aw_first;
  logic        axi_aw_last;

  // Read address channel
  logic        axi_ar_valid;
  logic        axi_ar_ready;
  logic [31:0] axi_ar_payload_addr;
  logic [7:0]  axi_ar_payload_len;
  logic [1:0]  axi_ar_payload_burst;
  logic        axi_ar_payload_id;
  logic [3:0]  axi_ar_payload_size;
  logic [1:0]  axi_ar_payload_lock;
  logic [2:0]  axi_ar_payload_prot;
  logic [3:0]  axi_ar_payload_cache;
  logic [3:0]  axi_ar_payload_qos;
  logic        axi_ar_first;
  logic        axi_ar_last;

  // Write response channel
  logic        axi_b_valid;
  logic        axi_b_ready;
  logic [1:0]  axi_b_payload_resp;
  logic        axi_b_payload_id;
  logic        axi_b_first;
  logic        axi_b_last;

  // Native per-beat command port
  logic        native_cmd_valid;
  logic        native_cmd_ready;
  logic        native_cmd_payload_we;
  logic [26:0] native_cmd_payload_addr;
  logic        native_cmd_first;
  logic        native_cmd_last;

  // Oldest outstanding write burst has completed
  logic        wr_done;

  modport slave (
    input  axi_aw_valid, axi_aw_payload_addr, axi_aw_payload_len, axi_aw_payload_burst,
           axi_aw_payload_id, axi_aw_payload_size, axi_aw_payload_lock, axi_aw_payload_prot,
           axi_aw_payload_cache, axi_aw_payload_qos, axi_aw_first, axi_aw_last,
    output axi_aw_ready,
    input  axi_ar_valid, axi_ar_payload_addr, axi_ar_payload_len, axi_ar_payload_burst,
           axi_ar_payload_id, axi_ar_payload_size, axi_ar_payload_lock, axi_ar_payload_prot,
           axi_ar_payload_cache, axi_ar_payload_qos, axi_ar_first, axi_ar_last,
    output axi_ar_ready,
    output axi_b_valid, axi_b_payload_resp, axi_b_payload_id, axi_b_first, axi_b_last,
    input  axi_b_ready,
    output native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
           native_cmd_first, native_cmd_last,
    input  native_cmd_ready,
    input  wr_done
  );

  modport master (
    output axi_aw_valid, axi_aw_payload_addr, axi_aw_payload_len, axi_aw_payload_burst,
           axi_aw_payload_id, axi_aw_payload_size, axi_aw_payload_lock, axi_aw_payload_prot,
           axi_aw_payload_cache, axi_aw_payload_qos, axi_aw_first, axi_aw_last,
    input  axi_aw_ready,
    output axi_ar_valid, axi_ar_payload_addr, axi_ar_payload_len, axi_ar_payload_burst,
           axi_ar_payload_id, axi_ar_payload_size, axi_ar_payload_lock, axi_ar_payload_prot,
           axi_ar_payload_cache, axi_ar_payload_qos, axi_ar_first, axi_ar_last,
    input  axi_ar_ready,
    input  axi_b_valid, axi_b_payload_resp, axi_b_payload_id, axi_b_first, axi_b_last,
    output axi_b_ready,
    input  native_cmd_valid, native_cmd_payload_we, native_cmd_payload_addr,
           native_cmd_first, native_cmd_last,
    output native_cmd_ready,
    output wr_done
  );

endinterface

// File: rtl/axi_cmd_frontend.sv
// AXI command front-end: arbitrates AR/AW round-robin, splits each burst
// into one native command per 256-bit beat, and returns B responses in
// order as write bursts complete.
// Optional feature: define AXI_FE_WRAP_EN to honour WRAP bursts; without
// it WRAP is executed as INCR and no wrap logic is built.
module axi_cmd_frontend #(
  parameter int ID_FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  axi_cmd_frontend_if.slave bus
);

  localparam int PW = $clog2(ID_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_BURST = 2'd1;
  localparam logic [1:0] WR_BURST = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;

  logic [1:0]          state_q, state_d;
  logic                lastGrantAw_q, lastGrantAw_d;
  logic [26:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [1:0]          burst_q, burst_d;

  logic [ID_FIFO_DEPTH-1:0] idMem_q;
  logic [PW-1:0]       wrPtr_q, rdPtr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       doneCnt_q, doneCnt_d;

  logic isIdle, busy, fifoFull, arElig, awElig, grantAr, grantAw;
  logic cmdHs, lastBeat, push, pop, bValid, doneInc;
  logic [26:0] incAddr, nextAddr;
  logic unusedInputs;

  assign isIdle   = (state_q == IDLE);
  assign busy     = !isIdle;
  assign fifoFull = (count_q == CW'(ID_FIFO_DEPTH));
  assign arElig   = bus.axi_ar_valid;
  assign awElig   = bus.axi_aw_valid && !fifoFull;
  assign grantAr  = isIdle && arElig && (!awElig || lastGrantAw_q);
  assign grantAw  = isIdle && awElig && !grantAr;
  assign cmdHs    = busy && bus.native_cmd_ready;
  assign lastBeat = (beat_q == len_q);
  assign push     = grantAw;
  assign bValid   = (doneCnt_q != '0);
  assign pop      = bValid && bus.axi_b_ready;
  assign doneInc  = bus.wr_done && (doneCnt_q != count_q);
  assign incAddr  = addr_q + 27'd1;

`ifdef AXI_FE_WRAP_EN
  logic        wrapOk;
  logic [26:0] wrapMask;
  assign wrapOk   = (burst_q == 2'b10) &&
                    (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
  assign wrapMask = {23'd0, len_q[3:0]};
  // Wrap keeps the upper address bits and lets only the in-block bits roll over
  always_comb begin
    nextAddr = incAddr;
    if (burst_q == BURST_FIXED) nextAddr = addr_q;
    else if (wrapOk)            nextAddr = (addr_q & ~wrapMask) | (incAddr & wrapMask);
  end
`else
  // Without wrap support only FIXED holds the address; all else increments
  always_comb begin
    nextAddr = incAddr;
    if (burst_q == BURST_FIXED) nextAddr = addr_q;
  end
`endif

  // Burst sequencer: grant in IDLE, then step one beat per command handshake
  always_comb begin
    state_d       = state_q;
    lastGrantAw_d = lastGrantAw_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    burst_d       = burst_q;
    case (state_q)
      IDLE: begin
        if (grantAr) begin
          state_d       = RD_BURST;
          lastGrantAw_d = 1'b0;
          addr_d        = bus.axi_ar_payload_addr[31:5];
          len_d         = bus.axi_ar_payload_len;
          burst_d       = bus.axi_ar_payload_burst;
          beat_d        = 8'd0;
        end else if (grantAw) begin
          state_d       = WR_BURST;
          lastGrantAw_d = 1'b1;
          addr_d        = bus.axi_aw_payload_addr[31:5];
          len_d         = bus.axi_aw_payload_len;
          burst_d       = bus.axi_aw_payload_burst;
          beat_d        = 8'd0;
        end
      end
      RD_BURST, WR_BURST: begin
        if (cmdHs) begin
          if (lastBeat) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
            addr_d = nextAddr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding-write bookkeeping; a completion is dropped if nothing is left to complete
  always_comb begin
    count_d   = count_q + CW'(push) - CW'(pop);
    doneCnt_d = doneCnt_q;
    if (doneInc && !pop)      doneCnt_d = doneCnt_q + CW'(1);
    else if (!doneInc && pop) doneCnt_d = doneCnt_q - CW'(1);
  end

  // State registers; reset abandons any burst and all pending responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lastGrantAw_q <= 1'b1;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      burst_q       <= '0;
      count_q       <= '0;
      doneCnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      lastGrantAw_q <= lastGrantAw_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      burst_q       <= burst_d;
      count_q       <= count_d;
      doneCnt_q     <= doneCnt_d;
    end
  end

  // Write-ID FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idMem_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (push) begin
        idMem_q[wrPtr_q] <= bus.axi_aw_payload_id;
        wrPtr_q          <= wrPtr_q + PW'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + PW'(1);
    end
  end

  assign bus.axi_ar_ready            = grantAr;
  assign bus.axi_aw_ready            = grantAw;
  assign bus.native_cmd_valid        = busy;
  assign bus.native_cmd_payload_we   = (state_q == WR_BURST);
  assign bus.native_cmd_payload_addr = busy ? addr_q : '0;
  assign bus.native_cmd_first        = busy && (beat_q == 8'd0);
  assign bus.native_cmd_last         = busy && lastBeat;
  assign bus.axi_b_valid             = bValid;
  assign bus.axi_b_payload_resp      = 2'b00;
  assign bus.axi_b_payload_id        = bValid && idMem_q[rdPtr_q];
  assign bus.axi_b_first             = bValid;
  assign bus.axi_b_last              = bValid;

  assign unusedInputs = ^{bus.axi_aw_payload_addr[4:0], bus.axi_aw_payload_size,
                          bus.axi_aw_payload_lock, bus.axi_aw_payload_prot,
                          bus.axi_aw_payload_cache, bus.axi_aw_payload_qos,
                          bus.axi_aw_first, bus.axi_aw_last,
                          bus.axi_ar_payload_addr[4:0], bus.axi_ar_payload_id,
                          bus.axi_ar_payload_size, bus.axi_ar_payload_lock,
                          bus.axi_ar_payload_prot, bus.axi_ar_payload_cache,
                          bus.axi_ar_payload_qos, bus.axi_ar_first, bus.axi_ar_last};

endmodule

// File: tb/tb_axi_cmd_frontend.sv
// Directed, table-driven bench for axi_cmd_frontend. Each vector is one
// clock cycle: inputs are driven after the falling edge and outputs are
// compared 1 time unit later, well away from the rising edge.
// WRAP expectations follow AXI_FE_WRAP_EN as defined for the build.
module tb_axi_cmd_frontend;

`ifdef AXI_FE_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif
  localparam int WA2 = WRAP_ON ? 4 : 8;
  localparam int WA3 = WRAP_ON ? 5 : 9;

  typedef struct {
    logic        arV, awV;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic        id, cmdRdy, bRdy, wrDone;
    logic        arR, awR, cv, we, fi, la;
    logic [26:0] cAddr;
    logic        bv, bid;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nVec = 0;
  int   nMiss = 0;
  vec_t tbl[$];

  axi_cmd_frontend_if bus();

  axi_cmd_frontend #(.ID_FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Build one cycle record: inputs first, then the required outputs
  function automatic vec_t v(input int arV, awV, addr, len, burst, id, cmdRdy, bRdy, wrDone,
                             input int arR, awR, cv, we, fi, la, cAddr, bv, bid);
    vec_t r;
    r.arV = arV[0]; r.awV = awV[0]; r.addr = 32'(addr); r.len = 8'(len);
    r.burst = 2'(burst); r.id = id[0]; r.cmdRdy = cmdRdy[0]; r.bRdy = bRdy[0];
    r.wrDone = wrDone[0]; r.arR = arR[0]; r.awR = awR[0]; r.cv = cv[0]; r.we = we[0];
    r.fi = fi[0]; r.la = la[0]; r.cAddr = 27'(cAddr); r.bv = bv[0]; r.bid = bid[0];
    return r;
  endfunction

  // Drive one cycle of inputs after the falling edge and let them settle
  task automatic applyStimulus(input vec_t s);
    @(negedge clk);
    bus.axi_ar_valid         = s.arV;
    bus.axi_aw_valid         = s.awV;
    bus.axi_ar_payload_addr  = s.addr;
    bus.axi_aw_payload_addr  = s.addr;
    bus.axi_ar_payload_len   = s.len;
    bus.axi_aw_payload_len   = s.len;
    bus.axi_ar_payload_burst = s.burst;
    bus.axi_aw_payload_burst = s.burst;
    bus.axi_ar_payload_id    = s.id;
    bus.axi_aw_payload_id    = s.id;
    bus.native_cmd_ready     = s.cmdRdy;
    bus.axi_b_ready          = s.bRdy;
    bus.wr_done              = s.wrDone;
    #1;
  endtask

  // Compare every DUT output against the record's required values
  task automatic checkOutput(input string name, input vec_t e);
    logic [38:0] act, req;
    act = {bus.axi_ar_ready, bus.axi_aw_ready, bus.native_cmd_valid,
           bus.native_cmd_payload_we, bus.native_cmd_first, bus.native_cmd_last,
           bus.native_cmd_payload_addr, bus.axi_b_valid, bus.axi_b_payload_resp,
           bus.axi_b_first, bus.axi_b_last, bus.axi_b_payload_id};
    req = {e.arR, e.awR, e.cv, e.we, e.fi, e.la, e.cAddr, e.bv, 2'b00, e.bv, e.bv, e.bid};
    nVec++;
    if (act !== req) begin
      nMiss++;
      $display("[TB] FAIL %s: actual arR,awR,cv,we,first,last=%b addr=%h b(v,resp,f,l,id)=%b ; required %b addr=%h b=%b",
               name, act[38:33], act[32:6], act[5:0], req[38:33], req[32:6], req[5:0]);
    end
  endtask

  initial begin
    bus.axi_aw_valid = 0; bus.axi_aw_payload_addr = 0; bus.axi_aw_payload_len = 0;
    bus.axi_aw_payload_burst = 0; bus.axi_aw_payload_id = 0; bus.axi_aw_payload_size = 0;
    bus.axi_aw_payload_lock = 0; bus.axi_aw_payload_prot = 0; bus.axi_aw_payload_cache = 0;
    bus.axi_aw_payload_qos = 0; bus.axi_aw_first = 0; bus.axi_aw_last = 0;
    bus.axi_ar_valid = 0; bus.axi_ar_payload_addr = 0; bus.axi_ar_payload_len = 0;
    bus.axi_ar_payload_burst = 0; bus.axi_ar_payload_id = 0; bus.axi_ar_payload_size = 0;
    bus.axi_ar_payload_lock = 0; bus.axi_ar_payload_prot = 0; bus.axi_ar_payload_cache = 0;
    bus.axi_ar_payload_qos = 0; bus.axi_ar_first = 0; bus.axi_ar_last = 0;
    bus.axi_b_ready = 0; bus.native_cmd_ready = 0; bus.wr_done = 0;

    // Round-robin from reset: AR first, then alternate; also the B-path corners
    //                 arV awV addr   len b id cr br wd   arR awR cv we f l cAddr bv bid
    tbl.push_back(v(1,1,32'h20,0,1,0, 1,0,0,  1,0,0,0,0,0,0,0,0));
    tbl.push_back(v(1,1,32'h20,0,1,0, 1,0,0,  0,0,1,0,1,1,1,0,0));
    tbl.push_back(v(1,1,32'h20,0,1,0, 1,0,0,  0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(1,1,32'h20,0,1,0, 1,0,0,  0,0,1,1,1,1,1,0,0));
    tbl.push_back(v(1,1,32'h20,0,1,0, 1,0,0,  1,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,1,32'h20,0,1,0, 1,0,0,  0,0,1,0,1,1,1,0,0));
    tbl.push_back(v(1,1,32'h20,0,1,0, 1,0,0,  0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,1,1,1,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,1,  0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,1,1,  0,0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,1,0,  0,0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,1,0,  0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,1,  0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,0,  0,0,0,0,0,0,0,0,0));
    // AR INCR 0x40 len 3 -> words 2..5
    tbl.push_back(v(1,0,32'h40,3,1,0, 1,0,0,  1,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,1,0,2,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,0,3,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,0,4,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,1,5,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,0,0,0,0,0,0,0));
    // AW WRAP 0xC0 len 3 id 1, then completion and a B stalled two cycles
    tbl.push_back(v(0,1,32'hC0,3,2,1, 1,0,0,  0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,1,1,0,6,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,1,0,0,7,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,1,0,0,WA2,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,1,0,1,WA3,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,1,  0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,0,  0,0,0,0,0,0,0,1,1));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,0,  0,0,0,0,0,0,0,1,1));
    tbl.push_back(v(0,0,0,0,0,0,      0,1,0,  0,0,0,0,0,0,0,1,1));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,0,  0,0,0,0,0,0,0,0,0));
    // AR FIXED len 2: same word every beat
    tbl.push_back(v(1,0,32'h12345678,2,0,0, 1,0,0,  1,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,1,0,27'h91A2B3,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,0,27'h91A2B3,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,1,27'h91A2B3,0,0));
    // AR reserved burst at the top word: wraps modulo 2^27
    tbl.push_back(v(1,0,32'hFFFFFFE0,1,3,0, 1,0,0,  1,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,1,0,27'h7FFFFFF,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,0,0,0,0,0,0,0));
    // AR len 3 with native ready low three cycles on beat 1
    tbl.push_back(v(1,0,32'h0,3,1,0,  1,0,0,  1,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,0,  0,0,1,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,0,  0,0,1,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,0,  0,0,1,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,0,2,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,0,0,1,3,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,0,0,0,0,0,0,0));
    // WRAP with len 2 (not a legal wrap length) behaves as INCR
    tbl.push_back(v(0,1,32'h60,2,2,0, 1,0,0,  0,1,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,1,1,0,3,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,1,0,0,4,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      1,0,0,  0,0,1,1,0,1,5,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,1,  0,0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,1,0,  0,0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,      0,0,0,  0,0,0,0,0,0,0,0,0));

    // Reset state while reset is held
    #1;
    checkOutput("reset", v(0,0,0,0,0,0, 0,0,0, 0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset during beat 2 of a len-7 read while a B response is pending
    applyStimulus(v(0,1,0,0,1,1, 1,0,0, 0,1,0,0,0,0,0,0,0));
    checkOutput("rst_aw", v(0,1,0,0,1,1, 1,0,0, 0,1,0,0,0,0,0,0,0));
    applyStimulus(v(0,0,0,0,0,0, 1,0,0, 0,0,1,1,1,1,0,0,0));
    checkOutput("rst_wbeat", v(0,0,0,0,0,0, 1,0,0, 0,0,1,1,1,1,0,0,0));
    applyStimulus(v(1,0,0,7,1,0, 1,0,1, 1,0,0,0,0,0,0,0,0));
    checkOutput("rst_ar", v(1,0,0,7,1,0, 1,0,1, 1,0,0,0,0,0,0,0,0));
    for (int b = 0; b < 3; b++) begin
      applyStimulus(v(0,0,0,0,0,0, 1,0,0, 0,0,1,0,(b == 0),0,b,1,1));
      checkOutput($sformatf("rst_beat%0d", b), v(0,0,0,0,0,0, 1,0,0, 0,0,1,0,(b == 0),0,b,1,1));
    end
    rst = 1'b1;
    #1;
    checkOutput("rst_async", v(0,0,0,0,0,0, 1,0,0, 0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(v(0,0,0,0,0,0, 1,0,0, 0,0,0,0,0,0,0,0,0));
    checkOutput("post_rst_idle", v(0,0,0,0,0,0, 1,0,0, 0,0,0,0,0,0,0,0,0));
    applyStimulus(v(1,0,32'h100,1,1,0, 1,0,0, 1,0,0,0,0,0,0,0,0));
    checkOutput("post_rst_ar", v(1,0,32'h100,1,1,0, 1,0,0, 1,0,0,0,0,0,0,0,0));
    applyStimulus(v(0,0,0,0,0,0, 1,0,0, 0,0,1,0,1,0,8,0,0));
    checkOutput("post_rst_b0", v(0,0,0,0,0,0, 1,0,0, 0,0,1,0,1,0,8,0,0));
    applyStimulus(v(0,0,0,0,0,0, 1,0,0, 0,0,1,0,0,1,9,0,0));
    checkOutput("post_rst_b1", v(0,0,0,0,0,0, 1,0,0, 0,0,1,0,0,1,9,0,0));

    // Fill the write-ID FIFO, then check AW blocking and AR bypass
    for (int k = 0; k < 4; k++) begin
      applyStimulus(v(0,1,k * 32,0,1,k % 2, 1,0,0, 0,1,0,0,0,0,0,0,0));
      checkOutput($sformatf("fill_aw%0d", k), v(0,1,k * 32,0,1,k % 2, 1,0,0, 0,1,0,0,0,0,0,0,0));
      applyStimulus(v(0,0,0,0,0,0, 1,0,0, 0,0,1,1,1,1,k,0,0));
      checkOutput($sformatf("fill_cmd%0d", k), v(0,0,0,0,0,0, 1,0,0, 0,0,1,1,1,1,k,0,0));
    end
    applyStimulus(v(1,1,32'h200,0,1,1, 1,0,0, 1,0,0,0,0,0,0,0,0));
    checkOutput("full_ar_only", v(1,1,32'h200,0,1,1, 1,0,0, 1,0,0,0,0,0,0,0,0));
    applyStimulus(v(0,1,32'h200,0,1,1, 1,0,0, 0,0,1,0,1,1,16,0,0));
    checkOutput("full_ar_cmd", v(0,1,32'h200,0,1,1, 1,0,0, 0,0,1,0,1,1,16,0,0));
    applyStimulus(v(0,1,32'h200,0,1,1, 1,0,1, 0,0,0,0,0,0,0,0,0));
    checkOutput("full_wrdone", v(0,1,32'h200,0,1,1, 1,0,1, 0,0,0,0,0,0,0,0,0));
    applyStimulus(v(0,1,32'h200,0,1,1, 1,1,0, 0,0,0,0,0,0,0,1,0));
    checkOutput("full_bresp", v(0,1,32'h200,0,1,1, 1,1,0, 0,0,0,0,0,0,0,1,0));
    applyStimulus(v(0,1,32'h200,0,1,1, 1,0,0, 0,1,0,0,0,0,0,0,0));
    checkOutput("fifth_aw", v(0,1,32'h200,0,1,1, 1,0,0, 0,1,0,0,0,0,0,0,0));
    applyStimulus(v(0,0,0,0,0,0, 1,0,0, 0,0,1,1,1,1,16,0,0));
    checkOutput("fifth_cmd", v(0,0,0,0,0,0, 1,0,0, 0,0,1,1,1,1,16,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
